// File: rtl/buffer_fifo_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : buffer_fifo_sync_if
// Brief    : Producer/consumer valid-ready handshake bundle for the FIFO.
// Revision : 1.0
// ============================================================================
interface buffer_fifo_sync_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Environment side: drives the producer offer and the consumer take
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Buffer side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/buffer_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : buffer_fifo_sync
// Brief    : DEPTH-entry synchronous FIFO with valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module buffer_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    buffer_fifo_sync_if.slave  bus,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Status comes only from registered count, so ready/valid never loop
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid  & ~w_full;
    assign w_pop   = bus.out_ready & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_mem[0] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.in_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign count         = r_count;
    assign full          = w_full;
    assign empty         = w_empty;
endmodule
`default_nettype wire
